// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch PC, resolves branches and jumps from active-low
// flags, and counts retired instructions. Define PC_TRAP_EN to trap on misaligned targets.
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic [5:0]  branch_op,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] qa,
  input  logic        is_lt,
  input  logic        is_ltu,
  input  logic        is_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_vld,
  output logic        halted,
  output logic [31:0] instret
);

`ifdef PC_TRAP_EN
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT, ST_TRAP} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        fetch_vld_q;
  logic        halted_q;

  logic        taken;
  logic        jump_sel;
  logic [31:0] next_pc;

  // Branch ops and flags are active low; a low op bit selects that comparison.
  always_comb begin
    taken = (~branch_op[5] & ~is_zero) | (~branch_op[4] &  is_zero) |
            (~branch_op[3] & ~is_lt)   | (~branch_op[2] &  is_lt)   |
            (~branch_op[1] & ~is_ltu)  | (~branch_op[0] &  is_ltu);
    jump_sel = ~jalr | ~jal | taken;
    next_pc  = pc_q + 32'd4;
    if (!jalr) begin
      next_pc = (qa + imm) & 32'hFFFF_FFFE;
    end else if (!jal || taken) begin
      next_pc = pc_q + imm;
    end
  end

`ifdef PC_TRAP_EN
  logic misaligned;
  assign misaligned = jump_sel && (next_pc[1:0] != 2'b00);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VEC;
      instret_q   <= 32'd0;
      fetch_vld_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q     <= ST_RUN;
          fetch_vld_q <= 1'b1;
        end
        ST_RUN: begin
          if (stall) begin
            if (!halt) begin
              // The halting instruction retires but does not advance the PC.
              instret_q   <= instret_q + 32'd1;
              state_q     <= ST_HALT;
              fetch_vld_q <= 1'b0;
              halted_q    <= 1'b1;
            end
`ifdef PC_TRAP_EN
            else if (misaligned) begin
              pc_q        <= TRAP_VEC;
              state_q     <= ST_TRAP;
              fetch_vld_q <= 1'b0;
            end
`endif
            else begin
              pc_q      <= next_pc;
              instret_q <= instret_q + 32'd1;
            end
          end
        end
`ifdef PC_TRAP_EN
        ST_TRAP: begin
          state_q     <= ST_RUN;
          fetch_vld_q <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_vld = fetch_vld_q;
  assign halted    = halted_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver feeds directed and random cycles through a
// behavioural model that queues expected outputs; a monitor pops and compares after each edge.
module tb_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, halt, jal, jalr, is_lt, is_ltu, is_zero;
  logic [5:0]  branch_op;
  logic [31:0] imm, qa;
  logic [31:0] pc, pc_plus4, instret;
  logic        fetch_vld, halted;

  always #5 clk = ~clk;

  pc_unit #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .branch_op(branch_op),
    .jal(jal), .jalr(jalr), .imm(imm), .qa(qa), .is_lt(is_lt), .is_ltu(is_ltu),
    .is_zero(is_zero), .pc(pc), .pc_plus4(pc_plus4), .fetch_vld(fetch_vld),
    .halted(halted), .instret(instret)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        fv;
    logic        hl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Model state: 0 boot, 1 run, 2 halt, 3 trap
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'd0;
  logic [31:0] m_cnt  = 32'd0;

  function automatic void model_step();
    bit          eq, lt, ltu, take, jumping;
    logic [31:0] tgt;
    exp_t        e;
    if (rst) begin
      m_mode = 0; m_pc = RESET_VEC; m_cnt = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        3: m_mode = 1;
        1: if (stall) begin
          if (!halt) begin
            m_cnt  = m_cnt + 1;
            m_mode = 2;
          end else begin
            eq  = !is_zero;
            lt  = !is_lt;
            ltu = !is_ltu;
            take = (!branch_op[5] && eq) || (!branch_op[4] && !eq) ||
                   (!branch_op[3] && lt) || (!branch_op[2] && !lt) ||
                   (!branch_op[1] && ltu) || (!branch_op[0] && !ltu);
            jumping = 1'b1;
            if (!jalr)              tgt = (qa + imm) & ~32'd1;
            else if (!jal || take)  tgt = m_pc + imm;
            else begin              tgt = m_pc + 4; jumping = 1'b0; end
`ifdef PC_TRAP_EN
            if (jumping && (tgt % 4 != 0)) begin
              m_pc = TRAP_VEC; m_mode = 3;
            end else begin
              m_pc = tgt; m_cnt = m_cnt + 1;
            end
`else
            m_pc = tgt; m_cnt = m_cnt + 1;
`endif
          end
        end
        default: ;
      endcase
    end
    e.pc = m_pc; e.pc4 = m_pc + 4; e.cnt = m_cnt;
    e.fv = (m_mode == 1); e.hl = (m_mode == 2);
    exp_q.push_back(e);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, n_txn, act, req);
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc4);
      chk("instret", instret, e.cnt);
      chk("fetch_vld", {31'd0, fetch_vld}, {31'd0, e.fv});
      chk("halted", {31'd0, halted}, {31'd0, e.hl});
      $display("txn %0d pc=%h vld=%b halted=%b instret=%0d", n_txn, pc, fetch_vld, halted, instret);
    end
  end

  task automatic step(input logic r, input logic s, input logic h, input logic [5:0] b,
                      input logic jl, input logic jr, input logic [31:0] im, input logic [31:0] q,
                      input logic lt, input logic ltu, input logic z);
    @(negedge clk);
    rst = r; stall = s; halt = h; branch_op = b; jal = jl; jalr = jr;
    imm = im; qa = q; is_lt = lt; is_ltu = ltu; is_zero = z;
    model_step();
  endtask

  task automatic idle();
    step(0, 1, 1, 6'h3f, 1, 1, 32'd0, 32'd0, 1, 1, 1);
  endtask

  task automatic do_reset();
    step(1, 1, 1, 6'h3f, 1, 1, 32'd0, 32'd0, 1, 1, 1);
    step(1, 1, 1, 6'h3f, 1, 1, 32'd0, 32'd0, 1, 1, 1);
    idle();  // BOOT cycle
  endtask

  task automatic go_to(input logic [31:0] a);
    step(0, 1, 1, 6'h3f, 1, 0, 32'd0, a, 1, 1, 1);
  endtask

  initial begin
    int halt_cycles;
    int r;
    rst = 1; stall = 1; halt = 1; branch_op = 6'h3f; jal = 1; jalr = 1;
    imm = 0; qa = 0; is_lt = 1; is_ltu = 1; is_zero = 1;

    do_reset(); idle(); idle(); idle();
    go_to(32'h10); step(0, 1, 1, 6'b011111, 1, 1, 32'h20, 0, 1, 1, 0);
    go_to(32'h10); step(0, 1, 1, 6'b011111, 1, 1, 32'h20, 0, 1, 1, 1);
    go_to(32'h40); step(0, 1, 1, 6'h3f, 0, 0, 32'd0, 32'h1003, 1, 1, 1); idle();
    go_to(32'h8);
    step(0, 0, 1, 6'h3f, 1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 6'h3f, 1, 1, 0, 0, 1, 1, 1);
    step(0, 0, 1, 6'h3f, 0, 1, 32'h40, 0, 1, 1, 1);
    idle();
    go_to(32'h20); step(0, 1, 0, 6'h3f, 1, 1, 0, 0, 1, 1, 1);
    step(0, 1, 1, 6'h3f, 0, 1, 32'h40, 0, 1, 1, 1);
    step(0, 1, 1, 6'h3f, 0, 1, 32'h40, 0, 1, 1, 1);
    do_reset();
    step(0, 1, 1, 6'h3f, 0, 1, 32'h6, 0, 1, 1, 1); idle(); idle();
    // Wraparound at the top of the address space
    go_to(32'hFFFF_FFFC); idle(); idle();

    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      logic [5:0]  b;
      logic [31:0] im;
      r = $urandom_range(0, 9);
      b = (r < 6) ? ~(6'b1 << r) : 6'h3f;
      im = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom_range(0, 63) << 2) - 32'd128);
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
      step((halt_cycles > 3) || ($urandom_range(0, 199) == 0),
           $urandom_range(0, 4) != 0, $urandom_range(0, 39) != 0, b,
           $urandom_range(0, 5) != 0, $urandom_range(0, 7) != 0, im, $urandom,
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
